// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b types used by the memory-side blocks: word/line widths and the
// arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single pmem port between the I-cache and D-cache, one line
// transaction at a time, alternating priority when both miss together.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = $bits(lc3b_word),
    parameter int LINE_W = $bits(lc3b_block)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              busy
);

    arb_state_t state;
    logic       last_d;
    logic       i_pend;
    logic       d_pend;
    logic       grant_d;

    assign i_pend  = i_read;
    assign d_pend  = d_read | d_write;
    // On a tie the requester not served last wins; after reset that is D.
    assign grant_d = d_pend & (~i_pend | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_d       <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // A simultaneous read+write request is serviced as the writeback.
                        state        <= SERVE_D;
                        busy         <= 1'b1;
                        pmem_address <= d_address;
                        pmem_wdata   <= d_wdata;
                        pmem_write   <= d_write;
                        pmem_read    <= ~d_write;
                    end else if (i_pend) begin
                        state        <= SERVE_I;
                        busy         <= 1'b1;
                        pmem_address <= i_address;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        last_d     <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        last_d     <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Read data is broadcast; only the per-requester resp qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign i_resp  = (state == SERVE_I) & pmem_resp;
    assign d_resp  = (state == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with hand-computed expectations.
module tb_cache_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;

    int assertCount;
    int failCount;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_WB = {2{64'h0123_4567_89AB_CDEF}};
    localparam logic [127:0] LINE_3C = {16{8'h3C}};

    cache_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [15:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [15:0] da, input logic [127:0] dwd);
        i_read    = ir;
        i_address = ia;
        d_read    = dr;
        d_write   = dw;
        d_address = da;
        d_wdata   = dwd;
        #1;
    endtask

    task automatic memReply(input logic resp, input logic [127:0] data);
        pmem_resp  = resp;
        pmem_rdata = data;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
        memReply(1'b0, '0);
        doReset();

        checkOutput("rst_pmem_read",  pmem_read,    0);
        checkOutput("rst_pmem_write", pmem_write,   0);
        checkOutput("rst_pmem_addr",  pmem_address, 0);
        checkOutput("rst_pmem_wdata", pmem_wdata,   0);
        checkOutput("rst_busy",       busy,         0);
        checkOutput("rst_i_resp",     i_resp,       0);
        checkOutput("rst_d_resp",     d_resp,       0);

        // Lone I-read, memory answers in the third serve cycle.
        applyStimulus(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0);
        checkOutput("i0_pmem_read", pmem_read, 0);
        tick();
        checkOutput("i1_pmem_read", pmem_read, 1);
        checkOutput("i1_addr", pmem_address, 16'h1230);
        checkOutput("i1_busy", busy, 1);
        tick();
        checkOutput("i2_pmem_read", pmem_read, 1);
        tick();
        memReply(1'b1, LINE_A5);
        checkOutput("i3_pmem_read", pmem_read, 1);
        checkOutput("i3_i_resp", i_resp, 1);
        checkOutput("i3_i_rdata", i_rdata, LINE_A5);
        checkOutput("i3_d_resp", d_resp, 0);
        tick();
        memReply(1'b0, '0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
        checkOutput("i4_busy", busy, 0);
        checkOutput("i4_pmem_read", pmem_read, 0);
        checkOutput("i4_i_resp", i_resp, 0);

        // D writeback; address changes mid-transaction must not leak through.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h4000, LINE_WB);
        tick();
        checkOutput("w1_pmem_write", pmem_write, 1);
        checkOutput("w1_pmem_read", pmem_read, 0);
        checkOutput("w1_addr", pmem_address, 16'h4000);
        checkOutput("w1_wdata", pmem_wdata, LINE_WB);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h5000, '0);
        tick();
        checkOutput("w2_addr_held", pmem_address, 16'h4000);
        checkOutput("w2_wdata_held", pmem_wdata, LINE_WB);
        checkOutput("w2_pmem_read", pmem_read, 0);
        memReply(1'b1, LINE_3C);
        checkOutput("w2_d_resp", d_resp, 1);
        checkOutput("w2_i_resp", i_resp, 0);
        checkOutput("w2_addr_at_resp", pmem_address, 16'h4000);
        tick();
        memReply(1'b0, '0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
        checkOutput("w3_busy", busy, 0);
        checkOutput("w3_pmem_write", pmem_write, 0);

        // Tie after reset: D, I, D with one idle cycle between grants.
        doReset();
        applyStimulus(1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, '0);
        tick();
        checkOutput("t1_addr_d", pmem_address, 16'h2000);
        checkOutput("t1_pmem_read", pmem_read, 1);
        memReply(1'b1, LINE_3C);
        checkOutput("t1_d_resp", d_resp, 1);
        checkOutput("t1_i_resp", i_resp, 0);
        checkOutput("t1_d_rdata", d_rdata, LINE_3C);
        tick();
        memReply(1'b0, '0);
        checkOutput("t2_idle_busy", busy, 0);
        checkOutput("t2_idle_read", pmem_read, 0);
        tick();
        checkOutput("t3_addr_i", pmem_address, 16'h1000);
        checkOutput("t3_busy", busy, 1);
        memReply(1'b1, LINE_A5);
        checkOutput("t3_i_resp", i_resp, 1);
        checkOutput("t3_d_resp", d_resp, 0);
        tick();
        memReply(1'b0, '0);
        checkOutput("t4_idle_busy", busy, 0);
        tick();
        checkOutput("t5_addr_d", pmem_address, 16'h2000);
        memReply(1'b1, LINE_3C);
        checkOutput("t5_d_resp", d_resp, 1);
        tick();
        memReply(1'b0, '0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);

        // Reset mid SERVE_I drops everything at once; a late response is ignored.
        applyStimulus(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0);
        tick();
        checkOutput("r1_pmem_read", pmem_read, 1);
        memReply(1'b1, LINE_A5);
        rst_n = 1'b0;
        #1;
        checkOutput("r1_async_read", pmem_read, 0);
        checkOutput("r1_async_busy", busy, 0);
        checkOutput("r1_async_i_resp", i_resp, 0);
        checkOutput("r1_async_addr", pmem_address, 0);
        memReply(1'b0, '0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
        tick();
        rst_n = 1'b1;
        #1;
        memReply(1'b1, LINE_A5);
        checkOutput("r2_late_i_resp", i_resp, 0);
        checkOutput("r2_late_d_resp", d_resp, 0);
        tick();
        memReply(1'b0, '0);
        checkOutput("r3_busy", busy, 0);

        // Stray response in IDLE, then simultaneous read+write.
        memReply(1'b1, LINE_3C);
        checkOutput("s1_i_resp", i_resp, 0);
        checkOutput("s1_d_resp", d_resp, 0);
        tick();
        memReply(1'b0, '0);
        checkOutput("s2_busy", busy, 0);
        checkOutput("s2_pmem_read", pmem_read, 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h6000, LINE_WB);
        tick();
        checkOutput("s3_pmem_write", pmem_write, 1);
        checkOutput("s3_pmem_read", pmem_read, 0);
        checkOutput("s3_addr", pmem_address, 16'h6000);
        memReply(1'b1, '0);
        checkOutput("s3_d_resp", d_resp, 1);
        tick();
        memReply(1'b0, '0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
        checkOutput("s4_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-requester arbiter that shares the single physical-memory (L2/pmem) port between the instruction cache and the data cache of the pipelined LC-3b core. Sits between the two L1 cache controllers and main memory. Grants one line-sized transaction at a time, alternates priority when both caches miss together, and routes `pmem_resp`/`pmem_rdata` back to the granted cache only.

## Interface
- `ADDR_W`, 16: byte address width (lc3b_word).
- `LINE_W`, 128: cache line width (lc3b_block, 8 words).
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  I-cache line-read request, held until `i_resp`.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_rdata`  out  LINE_W  line data to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_read`, `d_write`  in  1 each  D-cache line read / writeback request, held until `d_resp`.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  writeback line.
- `d_rdata`  out  LINE_W  line data to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `pmem_read`, `pmem_write`  out  1 each  memory strobes, held until `pmem_resp`.
- `pmem_address`  out  ADDR_W  memory line address.
- `pmem_wdata`  out  LINE_W  memory write line.
- `pmem_rdata`  in  LINE_W  memory read line.
- `pmem_resp`  in  1  memory completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: sample requests. I pending = `i_read`; D pending = `d_read | d_write`.
  - Only one pending -> grant it.
  - Both pending -> grant the one not served last (`last_d` flag); reset value `last_d=0`, so the first tie goes to D.
  - On grant: latch address and, for D, `d_wdata` plus op (`d_write` wins if `d_read` and `d_write` are both high; the read is dropped).
- SERVE_I / SERVE_D: drive `pmem_read` or `pmem_write` from latched op, `pmem_address`/`pmem_wdata` from latches. Requester inputs are ignored after the latch.
- On `pmem_resp`: combinationally pulse the granted `*_resp`, pass `pmem_rdata` to its `*_rdata`, update `last_d`, return to IDLE.
- `i_rdata`/`d_rdata` = `pmem_rdata` at all times; only `*_resp` qualifies them.
- `pmem_resp` in IDLE is ignored. No state change, no `*_resp`.
- Reset (any cycle, including mid-transaction): state -> IDLE, `last_d` -> 0, latches -> 0. All strobes, `*_resp` and `busy` go low immediately (asynchronously). An in-flight memory op is abandoned; the requester re-requests.

## Timing
- Grant latency: request high in IDLE at cycle N -> `pmem_*` strobe high from cycle N+1.
- Completion: `pmem_resp` in cycle M -> `*_resp` high in cycle M (same cycle), state IDLE at M+1.
- Requesters deassert in M+1. A request still high in M+1 is treated as a new request.
- Back-to-back: both pending continuously -> grants alternate D, I, D, I…, with one IDLE cycle between transactions.
- Minimum transaction = 2 cycles (grant cycle plus one memory cycle with immediate `pmem_resp`).
- Reset values: `pmem_read=0`, `pmem_write=0`, `pmem_address=0`, `pmem_wdata=0`, `i_resp=0`, `d_resp=0`, `busy=0`.

## Structure
- Add `lc3b_block` (128-bit line) and the arbiter state enum `arb_state_t` to `lc3b_types`. `lc3b_word` is used for addresses.
- Single module, no sub-module. State register, `last_d` flag, address/data/op latches, and a combinational output decode.

## Test plan
- Lone I-read at address 0x1230, memory replies 3 cycles later with line 0xA5…A5:
  - `pmem_read` high cycles 1–3, `pmem_address=0x1230`.
  - `i_resp` pulses in cycle 3 with `i_rdata` = the line.
  - `d_resp` stays 0.
- D-write at 0x4000 with `d_wdata=0x0123…EF`: `pmem_write` high, `pmem_wdata` matches, `d_resp` pulses on `pmem_resp`, `pmem_read` never high.
- `i_read` and `d_read` asserted together after reset and held: order of service is D, then I, then D. Each grant begins exactly one cycle after the previous `*_resp`.
- Change `d_address` from 0x4000 to 0x5000 mid-transaction: `pmem_address` stays 0x4000 until `pmem_resp`.
- Pulse `rst_n` low during SERVE_I: strobes, `busy`, `i_resp` drop immediately. A `pmem_resp` arriving after release produces no `*_resp`.
- Stray `pmem_resp` in IDLE and `d_read` with `d_write` simultaneously:
  - Stray response: no `*_resp`, state unchanged.
  - Simultaneous read/write: only `pmem_write` asserts.
